// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM encodings, default operand widths and
// the iteration-counter width helper used by the multiplier and divider control.
package arith_pkg;

    localparam int unsigned DIV_DW = 16;
    localparam int unsigned DIV_VW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple-borrow subtractor a - b built from the full_adder cell:
// a + ~b + 1, with borrow being the inverted final carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_subtractor #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    logic [W:0]   carry;
    logic [W-1:0] b_inv;

    assign carry[0] = 1'b1;
    assign b_inv    = ~b;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b_inv[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign borrow = ~carry[W];
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on operand and result sides.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          busy
);
    localparam int unsigned    CW   = cnt_width(DW);
    localparam logic [CW-1:0]  LAST = CW'(DW - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic [VW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   s_w;
    logic [VW:0]   t_w;
    logic          borrow_w;
    logic [DW-1:0] q_shift;
    logic [VW-1:0] r_next;
    logic          unused_t_msb;

    assign s_w = {r_q, q_q[DW-1]};

    ripple_subtractor #(.W(VW + 1)) u_sub (
        .a     (s_w),
        .b     ({1'b0, d_q}),
        .diff  (t_w),
        .borrow(borrow_w)
    );

    // R < D holds between iterations, so the top bit of T is zero whenever
    // the subtraction does not borrow and R fits in VW bits.
    assign unused_t_msb = t_w[VW];
    assign r_next       = borrow_w ? s_w[VW-1:0] : t_w[VW-1:0];
    assign q_shift      = {q_q[DW-2:0], ~borrow_w};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                q_d   = q_shift;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_shift;
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: the driver queues expected
// results on accept, a negedge monitor compares whenever out_valid is high.
module tb_seq_restoring_divider;
    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          busy;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        longint        acc;   // value of cyc right after the accept edge
        longint        lat;   // clock edges from accept edge to out_valid
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input logic ez);
        exp_t e;
        bit   acc = 1'b0;
        int   waited = 0;
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else waited++;
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.dvd = a;
        e.dvs = b;
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.acc = cyc + 1;
        // divide-by-zero result is registered on the accept edge itself
        e.lat = (b == '0) ? 0 : DW;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h00;
    endtask

    initial begin : monitor
        exp_t h;
        bit   prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    h = sb[0];
                    if (!prev_valid) begin
                        check("latency", cyc - h.acc, h.lat);
                        if (!h.z) begin
                            check("invariant",
                                  longint'(quotient) * longint'(h.dvs) + longint'(remainder),
                                  longint'(h.dvd));
                            check("rem_lt_div", longint'(remainder < h.dvs), 1);
                        end
                    end
                    check("quotient", quotient, h.q);
                    check("remainder", remainder, h.r);
                    check("div_by_zero", div_by_zero, h.z);
                    check("in_ready_done", in_ready, 0);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin : stimulus
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        int            waited;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        issue(16'd200,   8'd7,   16'd28,    8'd4,   1'b0);
        issue(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0);
        issue(16'd100,   8'd255, 16'd0,     8'd100, 1'b0);
        issue(16'd5,     8'd0,   16'hFFFF,  8'h05,  1'b1);
        issue(16'd0,     8'd9,   16'd0,     8'd0,   1'b0);
        issue(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0);
        issue(16'd255,   8'd16,  16'd15,    8'd15,  1'b0);
        issue(16'hABCD,  8'd0,   16'hFFFF,  8'hCD,  1'b1);

        // backpressure with a second operand pair already waiting
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                issue(16'd200, 8'd7, 16'd28, 8'd4, 1'b0);
                issue(16'd50,  8'd6, 16'd8,  8'd2, 1'b0);
            end
            begin
                waited = 0;
                do begin
                    @(negedge clk);
                    waited++;
                end while (!out_valid && waited < 100);
                check("bp_wait_valid", out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // asynchronous reset in the middle of a calculation
        issue(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_quotient", quotient, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        issue(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == '0) issue(a, b, 16'hFFFF, a[VW-1:0], 1'b1);
            else         issue(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
